// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one SRAM port between two requesters with bounded bursts.
// Optional ARB_STATS_EN adds saturating per-requester access counters acc_cnt0/acc_cnt1.
module sram_port_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wren,
  input  logic [DATA_W-1:0] sram_rdata,
`ifdef ARB_STATS_EN
  output logic              busy,
  output logic [15:0]       acc_cnt0,
  output logic [15:0]       acc_cnt1
`else
  output logic              busy
`endif
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          w_x, w_req_own, w_req_oth, w_wrap;
  assign gnt0       = (r_state == OWN0) & req0;
  assign gnt1       = (r_state == OWN1) & req1;
  assign sram_wren  = (gnt0 & we0) | (gnt1 & we1);
  assign sram_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
  assign sram_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
  assign rdata      = sram_rdata;
  assign busy       = r_state != IDLE;
  // w_x selects the current owner; OWN0 and OWN1 share one set of exit rules
  assign w_x        = r_state == OWN1;
  assign w_req_own  = w_x ? req1 : req0;
  assign w_req_oth  = w_x ? req0 : req1;
  assign w_wrap     = r_cnt == CW'(MAX_BURST - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (req0 & (~req1 | r_last)) r_state <= OWN0;
          else if (req1) r_state <= OWN1;
        end
        default: begin
          if (!w_req_own) begin
            r_cnt   <= '0;
            r_state <= w_req_oth ? (w_x ? OWN0 : OWN1) : IDLE;
          end else begin
            r_last <= w_x;
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap & w_req_oth) r_state <= w_x ? OWN0 : OWN1;
          end
        end
      endcase
    end
  end
`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt0 <= '0;
      acc_cnt1 <= '0;
    end else begin
      if (gnt0 & ~&acc_cnt0) acc_cnt0 <= acc_cnt0 + 16'd1;
      if (gnt1 & ~&acc_cnt1) acc_cnt1 <= acc_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: vector table, directed corner sequences and randomized traffic
// against a cycle-level behavioural model of the arbiter and SRAM.
module tb_sram_port_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, sram_wren, busy;
  logic [DW-1:0] rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;
`ifdef ARB_STATS_EN
  logic [15:0]   acc_cnt0, acc_cnt1;
`endif

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wren(sram_wren),
    .sram_rdata(sram_rdata),
`ifdef ARB_STATS_EN
    .busy(busy), .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
`else
    .busy(busy)
`endif
  );

  function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // SRAM: synchronous write, read data one cycle after the address
  logic [DW-1:0] smem [int];
  always @(posedge clk) begin
    sram_rdata <= smem.exists(int'(sram_addr)) ? smem[int'(sram_addr)] : dflt(sram_addr);
    if (sram_wren) smem[int'(sram_addr)] = sram_wdata;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    {req0, we0, req1, we1} = 4'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // fields: req0 we0 req1 we1 | gnt0 gnt1 wren busy
  typedef struct packed {logic r0, w0, r1, w1, g0, g1, wr, bz;} vec_t;
  vec_t tbl [13];

  // behavioural model state
  logic [DW-1:0] mmem [int];
  int            own, cnt, last, mc0, mc1, ma;
  logic          eg0, eg1, ewr, prv0, prv1, gs0, gs1, mine, oth;
  logic [AW-1:0] eaddr;
  logic [DW-1:0] ewd, pdat;
  logic          e0, e1, ev0, ev1;
  int            n0, n1;

  function automatic logic [DW-1:0] mread(int a);
    return mmem.exists(a) ? mmem[a] : dflt(AW'(a));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl = '{8'b1110_0000, 8'b1110_1011, 8'b0010_0001, 8'b0010_0101, 8'b0000_0001,
            8'b0000_0000, 8'b0011_0000, 8'b1011_0111, 8'b1000_0001, 8'b1000_1001,
            8'b0000_0001, 8'b1010_0000, 8'b1010_0101};

    // reset values, checked while reset is held
    do_reset;
    rst = 1'b0;
    #2;
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
    chk("rst_wren", 32'(sram_wren), 32'(0));
    chk("rst_addr", 32'(sram_addr), 32'(0));

    // vector table
    do_reset;
    addr0 = 18'h00030; addr1 = 18'h00040; wdata0 = 16'h1111; wdata1 = 16'h2222;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      {req0, we0, req1, we1} = {tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1};
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_wren", i), 32'(sram_wren), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("tbl%0d_addr", i), 32'(sram_addr),
          32'(tbl[i].g0 ? 18'h00030 : tbl[i].g1 ? 18'h00040 : 18'h0));
    end

    // write 0xABCD to 0x10 then read it back
    do_reset;
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00010; wdata0 = 16'hABCD;
    @(negedge clk);
    chk("wr_gnt_idle", 32'(gnt0), 32'(0));
    @(negedge clk);
    chk("wr_gnt", 32'(gnt0), 32'(1));
    chk("wr_wren", 32'(sram_wren), 32'(1));
    chk("wr_addr", 32'(sram_addr), 32'(18'h00010));
    chk("wr_wdata", 32'(sram_wdata), 32'(16'hABCD));
    @(posedge clk); #1 we0 = 1'b0;
    @(negedge clk);
    chk("rd_gnt", 32'(gnt0), 32'(1));
    chk("rd_wren", 32'(sram_wren), 32'(0));
    chk("rd_rvalid_early", 32'(rvalid0), 32'(0));
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid0", 32'(rvalid0), 32'(1));
    chk("rd_rvalid1", 32'(rvalid1), 32'(0));
    chk("rd_rdata", 32'(rdata), 32'(16'hABCD));

    // both requesters reading continuously: alternating bursts of MB
    do_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 18'h00200;
    req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00201;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      e0  = (c >= 1) && (((c - 1) / MB) % 2 == 0);
      e1  = (c >= 1) && (((c - 1) / MB) % 2 == 1);
      ev0 = (c >= 2) && (((c - 2) / MB) % 2 == 0);
      ev1 = (c >= 2) && (((c - 2) / MB) % 2 == 1);
      chk($sformatf("rr%0d_gnt0", c), 32'(gnt0), 32'(e0));
      chk($sformatf("rr%0d_gnt1", c), 32'(gnt1), 32'(e1));
      chk($sformatf("rr%0d_rvalid0", c), 32'(rvalid0), 32'(ev0));
      chk($sformatf("rr%0d_rvalid1", c), 32'(rvalid1), 32'(ev1));
      if (ev0 || ev1) chk($sformatf("rr%0d_rdata", c), 32'(rdata), 32'(dflt(ev0 ? addr0 : addr1)));
`ifdef ARB_STATS_EN
      chk($sformatf("rr%0d_acc0", c), 32'(acc_cnt0), 32'(n0));
      chk($sformatf("rr%0d_acc1", c), 32'(acc_cnt1), 32'(n1));
`endif
      n0 += int'(e0);
      n1 += int'(e1);
    end

    // asynchronous reset mid-burst with a read in flight
    #2 rst = 1'b0;
    #1;
    chk("arst_gnt", 32'({gnt0, gnt1}), 32'(0));
    chk("arst_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
    chk("arst_wren", 32'(sram_wren), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
`ifdef ARB_STATS_EN
    chk("arst_acc", 32'({acc_cnt0, acc_cnt1}), 32'(0));
`endif

    // requester 1 alone: granted every cycle, burst count wraps without a gap
    do_reset;
    req1 = 1'b1; we1 = 1'b1; addr1 = 18'h00300; wdata1 = 16'h5555;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      chk($sformatf("solo%0d_gnt1", c), 32'(gnt1), 32'(c >= 1));
      chk($sformatf("solo%0d_gnt0", c), 32'(gnt0), 32'(0));
    end

    // randomized traffic against the behavioural model
    do_reset;
    own = -1; cnt = 0; last = 1; mc0 = 0; mc1 = 0;
    prv0 = 1'b0; prv1 = 1'b0; gs0 = 1'b0; gs1 = 1'b0; pdat = '0;
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (gs0 || !req0) begin
        req0 = ($urandom_range(0, 3) != 0); we0 = 1'($urandom_range(0, 1));
        addr0 = AW'(32'h100 + $urandom_range(0, 15)); wdata0 = DW'($urandom);
      end
      if (gs1 || !req1) begin
        req1 = ($urandom_range(0, 3) != 0); we1 = 1'($urandom_range(0, 1));
        addr1 = AW'(32'h100 + $urandom_range(0, 15)); wdata1 = DW'($urandom);
      end
      @(negedge clk);
      eg0   = (own == 0) && req0;
      eg1   = (own == 1) && req1;
      ewr   = (eg0 && we0) || (eg1 && we1);
      eaddr = eg0 ? addr0 : eg1 ? addr1 : '0;
      ewd   = eg0 ? wdata0 : eg1 ? wdata1 : '0;
      chk("rnd_gnt0", 32'(gnt0), 32'(eg0));
      chk("rnd_gnt1", 32'(gnt1), 32'(eg1));
      chk("rnd_one_gnt", 32'(gnt0 & gnt1), 32'(0));
      chk("rnd_busy", 32'(busy), 32'(own >= 0));
      chk("rnd_wren", 32'(sram_wren), 32'(ewr));
      chk("rnd_addr", 32'(sram_addr), 32'(eaddr));
      chk("rnd_wdata", 32'(sram_wdata), 32'(ewd));
      chk("rnd_rvalid0", 32'(rvalid0), 32'(prv0));
      chk("rnd_rvalid1", 32'(rvalid1), 32'(prv1));
      if (prv0 || prv1) chk("rnd_rdata", 32'(rdata), 32'(pdat));
`ifdef ARB_STATS_EN
      chk("rnd_acc0", 32'(acc_cnt0), 32'(mc0));
      chk("rnd_acc1", 32'(acc_cnt1), 32'(mc1));
      if (eg0 && mc0 < 65535) mc0++;
      if (eg1 && mc1 < 65535) mc1++;
`endif
      gs0  = eg0;
      gs1  = eg1;
      prv0 = eg0 && !we0;
      prv1 = eg1 && !we1;
      if (eg0 || eg1) begin
        ma   = int'(eaddr);
        pdat = mread(ma);
        if (ewr) mmem[ma] = ewd;
      end
      if (own < 0) begin
        if (req0 && req1) own = 1 - last;
        else if (req0) own = 0;
        else if (req1) own = 1;
        cnt = 0;
      end else begin
        mine = (own == 0) ? req0 : req1;
        oth  = (own == 0) ? req1 : req0;
        if (!mine) begin
          own = oth ? 1 - own : -1;
          cnt = 0;
        end else begin
          last = own;
          cnt++;
          if (cnt == MB) begin
            cnt = 0;
            if (oth) own = 1 - own;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single 16-bit external SRAM port between two requesters: requester 0 is the upsampling/fetch stage, requester 1 is the colour-conversion datapath.
- Round-robin arbitration with a bounded burst length, so neither stage starves the other.
- Returns read data with a per-requester valid strobe.
- Sits between the stage controllers and the SRAM pins at the top level.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, SRAM data width
MAX_BURST, 8, max consecutive accesses granted to one requester while the other waits (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req0  in  1  requester 0 access request, held until granted
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 access performed this cycle
rvalid0  out  1  requester 0 read data valid on rdata
req1, we1, addr1, wdata1, gnt1, rvalid1: same roles for requester 1
rdata  out  DATA_W  read data, shared by both requesters, qualify with rvalidN
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_wren  out  1  SRAM write enable, active high
sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after the address
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous) values: state IDLE, burst count 0, last-served pointer = 1 (requester 0 wins the first tie), rvalid0/1 = 0.
  - Combinational outputs under reset: gnt0/1 = 0, sram_wren = 0, sram_addr/sram_wdata = 0.
- FSM states: IDLE, OWN0, OWN1. All transitions are at the clock edge.
- IDLE:
  - req0 only -> OWN0. req1 only -> OWN1.
  - Both requesting -> the requester not equal to the last-served pointer.
  - Neither requesting -> stay in IDLE.
  - Burst count is cleared on entry to any OWN state.
- OWNx:
  - gntx = reqx (combinational). An access occurs on every cycle with reqx & gntx.
  - sram_addr/sram_wdata/sram_wren are muxed combinationally from requester x; sram_wren = wex & access.
  - When no access is occurring: sram_wren = 0, sram_addr = 0, sram_wdata = 0.
- Burst count increments on each access.
- Last-served pointer is set to x on each access by x.
- Exit from OWNx:
  - reqx low -> go to other owner if its req is high, else IDLE. This is a non-access cycle.
  - Access with count == MAX_BURST-1 and other req high -> switch to other owner, count 0.
  - Access with count == MAX_BURST-1 and other req low -> stay in OWNx, count wraps to 0.
- Grant latency: a request rising in IDLE at cycle t is granted at t+1. A waiting requester is granted no later than MAX_BURST+1 cycles after the current owner's burst begins.
- Reads: rvalidx is a registered (we=0 & access by x), so it is high one cycle after the read grant. rdata = sram_rdata passthrough.
  - Back-to-back reads give one rvalid per cycle.
  - Switching owners does not corrupt an in-flight read: rvalid follows the requester that issued the read.
- Writes: complete in the grant cycle; no rvalid is generated.
- Requester contract: hold req/we/addr/wdata stable until gnt. Change addr/we/wdata per granted cycle for bursts.
- Reset mid-burst: all state returns to reset values immediately. An in-flight rvalid is dropped.
- Only one gnt is high in any cycle (invariant).

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs acc_cnt0 and acc_cnt1 (16 bits each).
  - Each counts granted accesses by its requester and saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted mid-operation -> gnt0/1=0, rvalid0/1=0, sram_wren=0, busy=0 asynchronously.
- req0 alone, write addr 0x00010 data 0xABCD, then read addr 0x00010 -> gnt0 one cycle after req; sram_wren=1 for one cycle; rvalid0 one cycle after read grant with rdata=0xABCD.
- req0 and req1 both raised from IDLE after reset -> requester 0 granted first (pointer reset=1).
- req0 and req1 both held continuously, MAX_BURST=8 -> exactly 8 gnt0, then 8 gnt1, repeating, never overlapping.
- req1 held alone for 20 cycles -> gnt1 every cycle from cycle 1; burst count wraps with no gap.
- Read by requester 0 in the last burst slot, then owner switches to requester 1 -> rvalid0 (not rvalid1) high on the following cycle; with ARB_STATS_EN, acc_cnt0 = 8 and acc_cnt1 matches the number of gnt1 cycles.
